// File: rtl/mvu_result_dma_if.sv
// Handshake bundle between the result DMA, the MVU data-RAM read port and the system write port.
interface mvu_result_dma_if;
    logic [14:0] mvu_rd_address;
    logic        mvu_rd_valid;
    logic        mvu_rd_ready;
    logic [63:0] mvu_rd_data;
    logic [31:0] dest_address;
    logic [31:0] dest_data;
    logic        dest_valid;
    logic        dest_ready;

    modport master (
        output mvu_rd_address, mvu_rd_valid, dest_address, dest_data, dest_valid,
        input  mvu_rd_ready, mvu_rd_data, dest_ready
    );

    modport slave (
        input  mvu_rd_address, mvu_rd_valid, dest_address, dest_data, dest_valid,
        output mvu_rd_ready, mvu_rd_data, dest_ready
    );
endinterface

// File: rtl/mvu_result_dma.sv
// Moves 64-bit words out of the MVU data RAM into system memory as pairs of 32-bit writes
// (low half first), raising a one-cycle irq and a sticky done flag on completion.
module mvu_result_dma (
    input  logic                     clk,
    input  logic                     rst,
    mvu_result_dma_if.master         bus,
    input  logic [14:0]              dma_source_addr_i,
    input  logic [31:0]              dma_dest_addr_i,
    input  logic [15:0]              dma_transfer_size_i,
    input  logic                     dma_transfer_start_i,
    output logic [31:0]              dma_status_o,
    output logic                     dma_irq
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WR_LO = 3'd2,
        WR_HI = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [14:0] src_r, src_s;
    logic [31:0] dst_r, dst_s;
    logic [15:0] size_r, size_s;
    logic [15:0] cnt_r, cnt_s;
    logic [63:0] buf_r, buf_s;
    logic        done_r, done_s;
    logic [31:0] dest_data_r, dest_data_s;
    logic        rd_valid_r;
    logic        dest_valid_r;
    logic        irq_r;
    logic [31:0] status_r;

    // Next-state and datapath updates; outputs are then registered from the next-state values
    always_comb begin
        state_s = state_r;
        src_s   = src_r;
        dst_s   = dst_r;
        size_s  = size_r;
        cnt_s   = cnt_r;
        buf_s   = buf_r;
        done_s  = done_r;
        case (state_r)
            IDLE: begin
                if (dma_transfer_start_i) begin
                    src_s  = dma_source_addr_i;
                    dst_s  = dma_dest_addr_i;
                    size_s = dma_transfer_size_i;
                    cnt_s  = 16'd0;
                    done_s = 1'b0;
                    if (dma_transfer_size_i == 16'd0) begin
                        state_s = DONE;
                    end else begin
                        state_s = READ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (bus.mvu_rd_ready) begin
                    buf_s   = bus.mvu_rd_data;
                    src_s   = src_r + 15'd1;
                    state_s = WR_LO;
                end else begin
                    state_s = READ;
                end
            end
            WR_LO: begin
                if (bus.dest_ready) begin
                    dst_s   = dst_r + 32'd4;
                    state_s = WR_HI;
                end else begin
                    state_s = WR_LO;
                end
            end
            WR_HI: begin
                if (bus.dest_ready) begin
                    dst_s = dst_r + 32'd4;
                    cnt_s = cnt_r + 16'd1;
                    // 16-bit compare so size 65535 terminates without wrapping the counter
                    if ((cnt_r + 16'd1) == size_r) begin
                        state_s = DONE;
                    end else begin
                        state_s = READ;
                    end
                end else begin
                    state_s = WR_HI;
                end
            end
            DONE: begin
                done_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        case (state_s)
            WR_LO:   dest_data_s = buf_s[31:0];
            WR_HI:   dest_data_s = buf_s[63:32];
            default: dest_data_s = 32'd0;
        endcase
    end

    // State, datapath and registered output flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            src_r        <= 15'd0;
            dst_r        <= 32'd0;
            size_r       <= 16'd0;
            cnt_r        <= 16'd0;
            buf_r        <= 64'd0;
            done_r       <= 1'b0;
            dest_data_r  <= 32'd0;
            rd_valid_r   <= 1'b0;
            dest_valid_r <= 1'b0;
            irq_r        <= 1'b0;
            status_r     <= 32'd0;
        end else begin
            state_r      <= state_s;
            src_r        <= src_s;
            dst_r        <= dst_s;
            size_r       <= size_s;
            cnt_r        <= cnt_s;
            buf_r        <= buf_s;
            done_r       <= done_s;
            dest_data_r  <= dest_data_s;
            rd_valid_r   <= (state_s == READ);
            dest_valid_r <= (state_s == WR_LO) || (state_s == WR_HI);
            irq_r        <= (state_s == DONE);
            status_r     <= {cnt_s, 14'd0, done_s, (state_s != IDLE)};
        end
    end

    assign bus.mvu_rd_address = src_r;
    assign bus.mvu_rd_valid   = rd_valid_r;
    assign bus.dest_address   = dst_r;
    assign bus.dest_data      = dest_data_r;
    assign bus.dest_valid     = dest_valid_r;
    assign dma_status_o       = status_r;
    assign dma_irq            = irq_r;

endmodule

// File: tb/tb_mvu_result_dma.sv
// Self-checking bench for mvu_result_dma: directed vector table, corner sequences and
// randomized transfers compared against a word-list model of the expected traffic.
module tb_mvu_result_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] src_i;
    logic [31:0] dst_i;
    logic [15:0] size_i;
    logic        start;
    logic [31:0] status;
    logic        irq;

    mvu_result_dma_if dbus();

    mvu_result_dma dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus                  (dbus),
        .dma_source_addr_i    (src_i),
        .dma_dest_addr_i      (dst_i),
        .dma_transfer_size_i  (size_i),
        .dma_transfer_start_i (start),
        .dma_status_o         (status),
        .dma_irq              (irq)
    );

    always #5 clk = ~clk;

    logic [63:0] ram [0:32767];
    int checks = 0;
    int errors = 0;
    int k;
    int irq_cnt;
    int irq_at;
    int ready_mode;
    int stall_left;
    logic [14:0] exp_src;
    logic [31:0] exp_dst;
    logic [14:0] rd_q [$];
    logic [63:0] wr_q [$];

    typedef struct {
        logic [14:0] src;
        logic [31:0] dst;
        logic [15:0] size;
        int          exp_cyc;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One bus cycle: drive readies/data at negedge, then observe what the next edge will accept
    task automatic cycle();
        @(negedge clk);
        k++;
        if (ready_mode == 1) begin
            dbus.mvu_rd_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            dbus.dest_ready   = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
        end else begin
            dbus.mvu_rd_ready = 1'b1;
            dbus.dest_ready   = 1'b1;
        end
        if (stall_left > 0 && dbus.dest_valid && (wr_q.size() % 2 == 1)) begin
            dbus.dest_ready = 1'b0;
            stall_left--;
            chk("stall_addr", {32'd0, dbus.dest_address}, {32'd0, exp_dst + 32'd4});
            chk("stall_data", {32'd0, dbus.dest_data}, {32'd0, ram[exp_src][63:32]});
            chk("stall_rdv", {63'd0, dbus.mvu_rd_valid}, 64'd0);
        end
        dbus.mvu_rd_data = ram[dbus.mvu_rd_address];
        #1;
        chk("excl_valid", {63'd0, dbus.mvu_rd_valid & dbus.dest_valid}, 64'd0);
        if (!dbus.dest_valid) chk("data_idle", {32'd0, dbus.dest_data}, 64'd0);
        if (dbus.mvu_rd_valid && dbus.mvu_rd_ready) rd_q.push_back(dbus.mvu_rd_address);
        if (dbus.dest_valid && dbus.dest_ready) wr_q.push_back({dbus.dest_address, dbus.dest_data});
        if (irq) begin
            irq_cnt++;
            if (irq_at < 0) irq_at = k;
        end
    endtask

    // Launch a transfer and, unless stopped early at stop_k, check it against the word-list model
    task automatic run(input logic [14:0] s, input logic [31:0] d, input logic [15:0] n,
                       input int mode, input int stall, input bit chg, input int stop_k);
        logic [14:0] rd_exp [$];
        logic [63:0] wr_exp [$];
        logic [63:0] w;
        logic [14:0] a;
        int budget;
        rd_q.delete(); wr_q.delete();
        irq_cnt = 0; irq_at = -1;
        ready_mode = mode; stall_left = stall;
        exp_src = s; exp_dst = d;
        @(negedge clk);
        src_i = s; dst_i = d; size_i = n; start = 1'b1;
        @(posedge clk);
        k = 0;
        #1 start = 1'b0;
        budget = 12 * int'(n) + 40;
        for (int c = 0; c < budget; c++) begin
            if (irq_at >= 0) break;
            if (stop_k != 0 && k == stop_k) break;
            if (chg && k == 2) begin
                src_i = 15'h0555; dst_i = 32'hDEAD_0000; size_i = 16'd7; start = 1'b1;
            end
            if (chg && k == 5) start = 1'b0;
            cycle();
        end
        if (stop_k == 0) begin
            chk("irq_seen", {63'd0, irq_at >= 0}, 64'd1);
            cycle();
            chk("irq_one", irq_cnt, 64'd1);
            chk("status_end", {32'd0, status}, {32'd0, n, 16'h0002});
            for (int i = 0; i < int'(n); i++) begin
                a = s + 15'(i);
                w = ram[a];
                rd_exp.push_back(a);
                wr_exp.push_back({d + 32'(8 * i), w[31:0]});
                wr_exp.push_back({d + 32'(8 * i + 4), w[63:32]});
            end
            chk("rd_count", rd_q.size(), rd_exp.size());
            chk("wr_count", wr_q.size(), wr_exp.size());
            for (int i = 0; i < rd_q.size() && i < rd_exp.size(); i++)
                chk("rd_addr", {49'd0, rd_q[i]}, {49'd0, rd_exp[i]});
            for (int i = 0; i < wr_q.size() && i < wr_exp.size(); i++)
                chk("wr_word", wr_q[i], wr_exp[i]);
        end
    endtask

    initial begin
        vec_t vecs [5];
        vecs[0] = '{15'h0010, 32'h8000_0000, 16'd2, 7};
        vecs[1] = '{15'h0020, 32'h0000_1000, 16'd0, 1};
        vecs[2] = '{15'h7FFF, 32'hFFFF_FFFC, 16'd2, 7};
        vecs[3] = '{15'h1234, 32'h0000_0100, 16'd1, 4};
        vecs[4] = '{15'h0200, 32'h0000_4000, 16'd5, 16};

        for (int i = 0; i < 32768; i++) ram[i] = {$urandom, $urandom};
        ram[15'h0010] = 64'h1122_3344_5566_7788;
        ram[15'h0011] = 64'h99AA_BBCC_DDEE_FF00;

        rst = 1'b1; start = 1'b0; src_i = 15'd0; dst_i = 32'd0; size_i = 16'd0;
        dbus.mvu_rd_ready = 1'b0; dbus.dest_ready = 1'b0; dbus.mvu_rd_data = 64'd0;
        ready_mode = 0; stall_left = 0; irq_cnt = 0; irq_at = -1; k = 0;
        repeat (2) @(negedge clk);
        chk("rst_rdv", {63'd0, dbus.mvu_rd_valid}, 64'd0);
        chk("rst_dv", {63'd0, dbus.dest_valid}, 64'd0);
        chk("rst_irq", {63'd0, irq}, 64'd0);
        chk("rst_status", {32'd0, status}, 64'd0);
        chk("rst_addr", {17'd0, dbus.mvu_rd_address, dbus.dest_address}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run(vecs[i].src, vecs[i].dst, vecs[i].size, 0, 0, 1'b0, 0);
            chk("irq_cycle", irq_at, vecs[i].exp_cyc);
        end

        // Literal traffic for the reference example and the address-wrap example
        run(15'h0010, 32'h8000_0000, 16'd2, 0, 0, 1'b0, 0);
        chk("ex_w0", wr_q[0], 64'h8000_0000_5566_7788);
        chk("ex_w1", wr_q[1], 64'h8000_0004_1122_3344);
        chk("ex_w2", wr_q[2], 64'h8000_0008_DDEE_FF00);
        chk("ex_w3", wr_q[3], 64'h8000_000C_99AA_BBCC);
        chk("ex_status", {32'd0, status}, 64'h0000_0000_0002_0002);
        run(15'h7FFF, 32'hFFFF_FFFC, 16'd2, 0, 0, 1'b0, 0);
        chk("wrap_rd0", {49'd0, rd_q[0]}, 64'h7FFF);
        chk("wrap_rd1", {49'd0, rd_q[1]}, 64'h0000);
        chk("wrap_wa1", {32'd0, wr_q[1][63:32]}, 64'h0);
        chk("wrap_wa2", {32'd0, wr_q[2][63:32]}, 64'h4);
        chk("wrap_wa3", {32'd0, wr_q[3][63:32]}, 64'h8);

        // Five-cycle write stall in the first WR_HI
        run(15'h0300, 32'h0000_2000, 16'd2, 0, 5, 1'b0, 0);
        chk("stall_cycle", irq_at, 64'd12);

        // Restart attempts and config changes while busy
        run(15'h0400, 32'h0000_3000, 16'd3, 0, 0, 1'b1, 0);
        chk("chg_cycle", irq_at, 64'd10);

        // Reset in WR_LO of the third word
        run(15'h0500, 32'h0000_5000, 16'd4, 0, 0, 1'b0, 8);
        chk("pre_rst_dv", {63'd0, dbus.dest_valid}, 64'd1);
        chk("pre_rst_addr", {32'd0, dbus.dest_address}, 64'h5010);
        chk("pre_rst_data", {32'd0, dbus.dest_data}, {32'd0, ram[15'h0502][31:0]});
        rst = 1'b1;
        #1;
        chk("ab_rdv", {63'd0, dbus.mvu_rd_valid}, 64'd0);
        chk("ab_dv", {63'd0, dbus.dest_valid}, 64'd0);
        chk("ab_data", {32'd0, dbus.dest_data}, 64'd0);
        chk("ab_addr", {17'd0, dbus.mvu_rd_address, dbus.dest_address}, 64'd0);
        chk("ab_status", {32'd0, status}, 64'd0);
        chk("ab_irq", {63'd0, irq}, 64'd0);
        rd_q.delete(); wr_q.delete(); irq_cnt = 0;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (3) cycle();
        chk("ab_no_irq", irq_cnt, 64'd0);
        chk("ab_no_req", rd_q.size() + wr_q.size(), 64'd0);
        run(15'h0600, 32'h0000_6000, 16'd2, 0, 0, 1'b0, 0);
        chk("post_rst_cycle", irq_at, 64'd7);

        // Randomized transfers with random back-pressure
        for (int t = 0; t < 8; t++) begin
            run(15'($urandom), $urandom, 16'($urandom_range(1, 5)), 1, 0, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
